// File: rtl/mem_arb_pkg.sv
//==============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared encodings for the fetch/data memory-port arbiter.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Which CPU port currently owns the memory.
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/rr_arb2.sv
//==============================================================================
// Module  : rr_arb2
// Brief   : Two-way round-robin picker. On a tie the port that did not win
//           last time is chosen; a lone requester always wins.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   req_fetch,
  input  logic   req_data,
  input  owner_e last_owner,
  output logic   valid,
  output owner_e winner
);

  // Pure combinational pick from the current requests and the last owner.
  always_comb begin
    valid  = req_fetch | req_data;
    winner = OWN_FETCH;
    if (req_fetch && req_data) begin
      winner = (last_owner == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
    end else if (req_data) begin
      winner = OWN_DATA;
    end
  end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one single-port RAM between the instruction-fetch port
//           (read-only) and the data port (read/write). Round-robin grant,
//           one command in flight, fixed-latency read return.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  // Instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // Data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // Memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  // A zero-latency memory cannot be sequenced by this FSM.
  if (RD_LAT < 1) begin : g_bad_rd_lat
    $fatal(1, "mem_port_arbiter: RD_LAT must be >= 1");
  end

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              arb_valid;
  owner_e            arb_winner;

  rr_arb2 u_rr_arb2 (
    .req_fetch  (if_req),
    .req_data   (d_req),
    .last_owner (last_owner_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  // State, command latch, latency counter and read-data holding registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_FETCH;
      last_owner_q <= OWN_DATA;   // so fetch wins the first tie
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Next-state: arbitrate in IDLE/RESP, issue one cycle, count down, capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (arb_valid) begin
          state_d      = ST_ISSUE;
          owner_d      = arb_winner;
          last_owner_d = arb_winner;
          if (arb_winner == OWN_DATA) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            // The fetch port is read-only whatever d_we is doing.
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(RD_LAT);
        end
      end

      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          if (owner_q == OWN_DATA) begin
            d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    if_gnt    = (state_q == ST_ISSUE) && (owner_q == OWN_FETCH);
    d_gnt     = (state_q == ST_ISSUE) && (owner_q == OWN_DATA);
    if_rvalid = (state_q == ST_RESP)  && (owner_q == OWN_FETCH);
    d_rvalid  = (state_q == ST_RESP)  && (owner_q == OWN_DATA);
    mem_en    = (state_q == ST_ISSUE);
    mem_we    = (state_q == ST_ISSUE) && we_q && (owner_q == OWN_DATA);
    mem_addr  = (state_q == ST_ISSUE) ? addr_q  : '0;
    mem_wdata = (state_q == ST_ISSUE) ? wdata_q : '0;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed self-checking bench for mem_port_arbiter (RD_LAT=1 and
//           RD_LAT=3 builds, each with a behavioural RAM).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;

  // RD_LAT=1 instance signals
  logic        if_req, d_req, d_we;
  logic [7:0]  if_addr, d_addr;
  logic [15:0] d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [15:0] if_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  // RD_LAT=3 instance signals
  logic        r3_if_req, r3_d_req, r3_d_we;
  logic [7:0]  r3_if_addr, r3_d_addr;
  logic [15:0] r3_d_wdata;
  logic        r3_if_gnt, r3_if_rvalid, r3_d_gnt, r3_d_rvalid;
  logic [15:0] r3_if_rdata, r3_d_rdata;
  logic        r3_mem_en, r3_mem_we;
  logic [7:0]  r3_mem_addr;
  logic [15:0] r3_mem_wdata, r3_mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .if_req(r3_if_req), .if_addr(r3_if_addr), .if_gnt(r3_if_gnt),
    .if_rvalid(r3_if_rvalid), .if_rdata(r3_if_rdata),
    .d_req(r3_d_req), .d_we(r3_d_we), .d_addr(r3_d_addr), .d_wdata(r3_d_wdata),
    .d_gnt(r3_d_gnt), .d_rvalid(r3_d_rvalid), .d_rdata(r3_d_rdata),
    .mem_en(r3_mem_en), .mem_we(r3_mem_we), .mem_addr(r3_mem_addr),
    .mem_wdata(r3_mem_wdata), .mem_rdata(r3_mem_rdata)
  );

  // Fixed background contents for locations never written.
  function automatic logic [15:0] preset(input logic [7:0] a);
    case (a)
      8'h10:   preset = 16'hBEEF;
      8'h05:   preset = 16'hA5C3;
      default: preset = {a, ~a};
    endcase
  endfunction

  // Behavioural RAM, 1-cycle read latency.
  bit [15:0] wmem1 [256];
  bit        wv1   [256];
  logic [15:0] pipe1 = 16'h0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wmem1[mem_addr] <= mem_wdata;
      wv1[mem_addr]   <= 1'b1;
    end
    if (mem_en && !mem_we) pipe1 <= wv1[mem_addr] ? wmem1[mem_addr] : preset(mem_addr);
    else                   pipe1 <= 16'h0;
  end
  assign mem_rdata = pipe1;

  // Behavioural RAM, 3-cycle read latency (data only valid in its slot).
  bit [15:0] wmem3 [256];
  bit        wv3   [256];
  logic [15:0] p3_0 = 16'h0, p3_1 = 16'h0, p3_2 = 16'h0;
  always @(posedge clk) begin
    if (r3_mem_en && r3_mem_we) begin
      wmem3[r3_mem_addr] <= r3_mem_wdata;
      wv3[r3_mem_addr]   <= 1'b1;
    end
    if (r3_mem_en && !r3_mem_we)
      p3_0 <= wv3[r3_mem_addr] ? wmem3[r3_mem_addr] : preset(r3_mem_addr);
    else
      p3_0 <= 16'h0;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign r3_mem_rdata = p3_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] e_ifg, e_dg, e_ifv, e_dv;

  initial begin
    reset_n = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    r3_if_req = 0; r3_d_req = 0; r3_d_we = 0; r3_if_addr = 0; r3_d_addr = 0; r3_d_wdata = 0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_if_gnt", {31'b0, if_gnt}, 0);
    check("rst_mem_en", {31'b0, mem_en}, 0);
    check("rst_d_rvalid", {31'b0, d_rvalid}, 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // Single fetch from 0x10.
    if_req = 1; if_addr = 8'h10;
    step();
    if_req = 0;
    check("f1_if_gnt", {31'b0, if_gnt}, 1);
    check("f1_d_gnt", {31'b0, d_gnt}, 0);
    check("f1_mem_en", {31'b0, mem_en}, 1);
    check("f1_mem_we", {31'b0, mem_we}, 0);
    check("f1_mem_addr", {24'b0, mem_addr}, 32'h10);
    step();
    check("f2_mem_en", {31'b0, mem_en}, 0);
    check("f2_if_rvalid", {31'b0, if_rvalid}, 0);
    step();
    check("f3_if_rvalid", {31'b0, if_rvalid}, 1);
    check("f3_if_rdata", {16'b0, if_rdata}, 32'hBEEF);
    step();
    check("f4_if_rvalid", {31'b0, if_rvalid}, 0);
    check("f4_if_rdata_hold", {16'b0, if_rdata}, 32'hBEEF);

    // Data write 0x20 <= 0x1234.
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 16'h1234;
    step();
    d_req = 0;
    check("w1_d_gnt", {31'b0, d_gnt}, 1);
    check("w1_if_gnt", {31'b0, if_gnt}, 0);
    check("w1_mem_we", {31'b0, mem_we}, 1);
    check("w1_mem_addr", {24'b0, mem_addr}, 32'h20);
    check("w1_mem_wdata", {16'b0, mem_wdata}, 32'h1234);
    step();
    check("w2_d_gnt", {31'b0, d_gnt}, 0);
    check("w2_mem_en", {31'b0, mem_en}, 0);

    // Data read back 0x20.
    d_req = 1; d_we = 0; d_addr = 8'h20;
    step();
    d_req = 0;
    check("r1_d_gnt", {31'b0, d_gnt}, 1);
    check("r1_mem_we", {31'b0, mem_we}, 0);
    step();
    check("r2_d_gnt", {31'b0, d_gnt}, 0);
    check("r2_d_rvalid", {31'b0, d_rvalid}, 0);
    step();
    check("r3_d_rvalid", {31'b0, d_rvalid}, 1);
    check("r3_d_rdata", {16'b0, d_rdata}, 32'h1234);
    check("r3_if_rvalid", {31'b0, if_rvalid}, 0);
    step();

    // Reset asserted in the middle of a fetch WAIT.
    if_req = 1; if_addr = 8'h10;
    step();
    if_req = 0;
    step();
    #2 reset_n = 1'b0;
    #1;
    check("rw_if_gnt", {31'b0, if_gnt}, 0);
    check("rw_mem_en", {31'b0, mem_en}, 0);
    check("rw_if_rdata", {16'b0, if_rdata}, 0);
    check("rw_d_rdata", {16'b0, d_rdata}, 0);
    step();
    reset_n = 1'b1;
    step();
    check("rw_post1_if_rvalid", {31'b0, if_rvalid}, 0);
    check("rw_post1_mem_en", {31'b0, mem_en}, 0);
    step();
    check("rw_post2_if_rvalid", {31'b0, if_rvalid}, 0);

    // Both ports requesting reads continuously: F, D, F, D grants.
    e_ifg = 16'h0082;  // cycles 1, 7
    e_dg  = 16'h0410;  // cycles 4, 10
    e_ifv = 16'h0208;  // cycles 3, 9
    e_dv  = 16'h1040;  // cycles 6, 12
    if_req = 1; if_addr = 8'h10; d_req = 1; d_we = 0; d_addr = 8'h20;
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("tie_if_gnt_c%0d", c), {31'b0, if_gnt}, {31'b0, e_ifg[c]});
      check($sformatf("tie_d_gnt_c%0d", c), {31'b0, d_gnt}, {31'b0, e_dg[c]});
      check($sformatf("tie_if_rvalid_c%0d", c), {31'b0, if_rvalid}, {31'b0, e_ifv[c]});
      check($sformatf("tie_d_rvalid_c%0d", c), {31'b0, d_rvalid}, {31'b0, e_dv[c]});
      if (e_ifv[c]) check("tie_if_rdata", {16'b0, if_rdata}, 32'hBEEF);
      if (e_dv[c])  check("tie_d_rdata", {16'b0, d_rdata}, 32'h1234);
    end
    if_req = 0; d_req = 0;
    step();
    check("tie_end_mem_en", {31'b0, mem_en}, 0);

    // Fetch owner while d_we is high on the inputs: no write to memory.
    if_req = 1; if_addr = 8'h10; d_we = 1; d_addr = 8'h30; d_wdata = 16'hFFFF;
    step();
    if_req = 0;
    check("guard_if_gnt", {31'b0, if_gnt}, 1);
    check("guard_mem_we", {31'b0, mem_we}, 0);
    check("guard_mem_addr", {24'b0, mem_addr}, 32'h10);
    step(); step();
    check("guard_if_rdata", {16'b0, if_rdata}, 32'hBEEF);
    step();
    d_we = 0;

    // A request dropped before the arbitration edge is never issued.
    if_req = 1;
    #2 if_req = 0;
    step();
    check("drop_mem_en", {31'b0, mem_en}, 0);
    check("drop_if_gnt", {31'b0, if_gnt}, 0);

    // RD_LAT=3 build: read 0x05, rvalid 5 cycles after the sampling edge.
    r3_d_req = 1; r3_d_we = 0; r3_d_addr = 8'h05;
    step();
    r3_d_req = 0;
    check("l3_c1_d_gnt", {31'b0, r3_d_gnt}, 1);
    check("l3_c1_mem_en", {31'b0, r3_mem_en}, 1);
    check("l3_c1_if_gnt", {31'b0, r3_if_gnt}, 0);
    for (int c = 2; c <= 4; c++) begin
      step();
      check($sformatf("l3_c%0d_mem_en", c), {31'b0, r3_mem_en}, 0);
      check($sformatf("l3_c%0d_d_rvalid", c), {31'b0, r3_d_rvalid}, 0);
    end
    step();
    check("l3_c5_d_rvalid", {31'b0, r3_d_rvalid}, 1);
    check("l3_c5_d_rdata", {16'b0, r3_d_rdata}, 32'hA5C3);
    check("l3_c5_if_rvalid", {31'b0, r3_if_rvalid}, 0);
    step();
    check("l3_c6_d_rvalid", {31'b0, r3_d_rvalid}, 0);
    check("l3_c6_if_rdata", {16'b0, r3_if_rdata}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_port_arbiter

`default_nettype wire
